muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_divstep.sv | 22 ++
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and default widths.
package muldiv_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_MULHU = 2'd1,
    OP_DIVU  = 2'd2,
    OP_REMU  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_div(input op_t o);
    return o[1];
  endfunction

  // MULHU and REMU both take the upper half of the accumulator.
  function automatic logic sel_high(input op_t o);
    return o[0];
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One combinational restoring-divide step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module muldiv_divstep #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  bit_in,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] partial;

  // rem < divisor always holds, so a successful difference fits in DATA_WIDTH bits.
  always_comb begin
    partial  = {rem, bit_in};
    q_bit    = (partial >= {1'b0, divisor});
    rem_next = q_bit ? DATA_WIDTH'(partial - {1'b0, divisor}) : partial[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU, one bit per cycle.
// Divider datapath is built only when MULDIV_DIV_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start; latches operands on start
// RUN     | DATA_WIDTH shift-add / shift-subtract steps
// DONE    | final select; outputs register on the following edge
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [ADDR_WIDTH-1:0] rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [ADDR_WIDTH-1:0] rd_out,
  output logic                  wb_enable
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic [2*DATA_WIDTH-1:0] acc, acc_step;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg;
  op_t                     op_reg;
  logic [ADDR_WIDTH-1:0]   rd_reg;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH-1:0]   fin_result;
  logic                    fin_wb;
  logic                    accept;
  logic                    go_done;

`ifdef MULDIV_DIV_EN
  logic                  div0_reg;
  logic [DATA_WIDTH-1:0] rem_next;
  logic                  q_bit;

  muldiv_divstep #(.DATA_WIDTH(DATA_WIDTH)) u_divstep (
    .rem      (acc[2*DATA_WIDTH-1:DATA_WIDTH]),
    .bit_in   (a_reg[DATA_WIDTH-1]),
    .divisor  (b_reg),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );
`endif

  // done is registered one edge after DONE, so the pulse cycle must also block start.
  assign accept = start && !done;
  assign busy   = (state != ST_IDLE) || done;

  always_comb begin
`ifdef MULDIV_DIV_EN
    go_done = is_div(op_t'(op)) && (operand_b == '0);
`else
    go_done = is_div(op_t'(op));
`endif
  end

  // Right-shifting product: the add lands in the upper half, low bits shift out of it.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, (b_reg[0] ? a_reg : '0)};
    acc_step = {mul_sum, acc[DATA_WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    if (is_div(op_reg)) acc_step = {rem_next, acc[DATA_WIDTH-2:0], q_bit};
`endif
  end

  always_comb begin
    fin_result = sel_high(op_reg) ? acc[2*DATA_WIDTH-1:DATA_WIDTH] : acc[DATA_WIDTH-1:0];
    fin_wb     = 1'b1;
`ifdef MULDIV_DIV_EN
    if (div0_reg) fin_result = (op_reg == OP_DIVU) ? '1 : a_reg;
`else
    if (is_div(op_reg)) begin
      fin_result = '0;
      fin_wb     = 1'b0;
    end
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = go_done ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt == CNT_LAST) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_MUL;
      rd_reg    <= '0;
      done      <= 1'b0;
      wb_enable <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
`ifdef MULDIV_DIV_EN
      div0_reg  <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      done      <= (state == ST_DONE);
      wb_enable <= (state == ST_DONE) && fin_wb;
      if (state == ST_DONE) begin
        result <= fin_result;
        rd_out <= rd_reg;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_reg  <= operand_a;
            b_reg  <= operand_b;
            op_reg <= op_t'(op);
            rd_reg <= rd_in;
            cnt    <= '0;
            acc    <= '0;
`ifdef MULDIV_DIV_EN
            div0_reg <= go_done;
`endif
          end
        end
        ST_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
`ifdef MULDIV_DIV_EN
          if (is_div(op_reg)) a_reg <= a_reg << 1;
          else                b_reg <= b_reg >> 1;
`else
          b_reg <= b_reg >> 1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops
// against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wb_enable;

  int vec_cnt = 0;
  int err_cnt = 0;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .wb_enable (wb_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
`ifdef MULDIV_DIV_EN
      2'd2: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
    if (o < 2'd2) return 33;
`ifdef MULDIV_DIV_EN
    return (b == 32'd0) ? 1 : 33;
`else
    return (b == b) ? 1 : 1;
`endif
  endfunction

  function automatic logic model_wb(input logic [1:0] o);
`ifdef MULDIV_DIV_EN
    return (o == o);
`else
    return (o < 2'd2);
`endif
  endfunction

  // Caller is positioned just after a rising edge; the next edge samples start.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input int intrude_at);
    int          lat;
    int          got_cyc;
    int          n_done;
    logic [31:0] exp;
    logic [31:0] res;
    logic [4:0]  rdo;
    logic        wbo;
    exp     = model_result(o, a, b);
    lat     = model_lat(o, b);
    got_cyc = 0;
    n_done  = 0;
    res     = 32'd0;
    rdo     = 5'd0;
    wbo     = 1'b0;
    start = 1'b1; op = o; operand_a = a; operand_b = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
    check_val({tag, " busy"}, busy, 1);
    for (int n = 1; n <= lat + 3; n++) begin
      operand_a = $urandom; operand_b = $urandom; op = 2'($urandom); rd_in = 5'($urandom);
      start = (n == intrude_at);
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (got_cyc == 0) begin
          got_cyc = n; res = result; rdo = rd_out; wbo = wb_enable;
        end
      end
    end
    start = 1'b0;
    check_val({tag, " latency"}, got_cyc, lat);
    check_val({tag, " done count"}, n_done, 1);
    check_val({tag, " result"}, res, exp);
    check_val({tag, " rd_out"}, rdo, rd);
    check_val({tag, " wb_enable"}, wbo, model_wb(o));
    check_val({tag, " idle"}, busy, 0);
    check_val({tag, " result hold"}, result, exp);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0; rd_in = '0;
    #1;
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_val("reset wb_enable", wb_enable, 0);
    check_val("reset result", result, 0);
    check_val("reset rd_out", rd_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op("mul 7x6", 2'd0, 32'd7, 32'd6, 5'd3, 0);
    do_op("mulhu ones", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 0);
    do_op("mul ones", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0);
    do_op("divu 100/7", 2'd2, 32'd100, 32'd7, 5'd11, 0);
    do_op("remu 100/7", 2'd3, 32'd100, 32'd7, 5'd12, 0);
    do_op("divu 5/0", 2'd2, 32'd5, 32'd0, 5'd13, 0);
    do_op("remu 5/0", 2'd3, 32'd5, 32'd0, 5'd14, 0);
    do_op("divu max/1", 2'd2, 32'hFFFF_FFFF, 32'd1, 5'd15, 0);
    do_op("second start ignored", 2'd0, 32'd1234, 32'd5678, 5'd17, 5);

    // Abort a multiply mid-run with an asynchronous reset.
    start = 1'b1; op = 2'd0; operand_a = 32'd1000; operand_b = 32'd1000; rd_in = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort busy", busy, 0);
    check_val("abort result", result, 0);
    check_val("abort done", done, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check_val("abort no done", done, 0);
      check_val("abort no wb", wb_enable, 0);
    end
    rst_n = 1'b1;
    do_op("mul after reset", 2'd0, 32'd3, 32'd4, 5'd21, 0);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) b = 32'($urandom_range(1, 15));
      else               b = $urandom;
      do_op("random", o, a, b, 5'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
